// File: rtl/apb2axi_pkg.sv
// apb2axi_pkg: state encoding, AXI response/burst constants and helpers shared by the
// APB-to-AXI bridge. Defining APB2AXI_TIMEOUT_EN adds the DRAIN state used after a
// response watchdog expiry.
package apb2axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
`ifdef APB2AXI_TIMEOUT_EN
    ,
    DRAIN   = 3'd6
`endif
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;

  localparam int TIMEOUT_CYCLES = 256;

  // Slave and decode errors both surface as an APB slave error.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/APB_BUS.sv
// APB_BUS: APB3 signal bundle with master and slave views.
interface APB_BUS #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
);
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [APB_DATA_WIDTH-1:0] pwdata;
  logic                      pwrite;
  logic                      psel;
  logic                      penable;
  logic [APB_DATA_WIDTH-1:0] prdata;
  logic                      pready;
  logic                      pslverr;

  modport Master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport Slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/AXI_BUS.sv
// AXI_BUS: AXI4 signal bundle (all five channels) with master and slave views.
interface AXI_BUS #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_USER_WIDTH = 6
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_qos;
  logic [3:0]                  aw_region;
  logic [AXI_USER_WIDTH-1:0]   aw_user;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_qos;
  logic [3:0]                  ar_region;
  logic [AXI_USER_WIDTH-1:0]   ar_user;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/apb2axi_timeout.sv
// apb2axi_timeout: response watchdog for the APB-to-AXI bridge. The module only exists
// when APB2AXI_TIMEOUT_EN is defined; the default build waits for responses forever.
`ifdef APB2AXI_TIMEOUT_EN
module apb2axi_timeout
  import apb2axi_pkg::*;
#(
  parameter int CYCLES = TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic active_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(CYCLES + 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Count consecutive response-wait cycles; the count restarts whenever the wait ends.
  always_comb begin
    count_d = '0;
    if (active_i) count_d = count_q + 1'b1;
  end

  // Watchdog counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  // Fires in the last allowed wait cycle so the bridge reacts on the following edge.
  assign expired_o = active_i && (count_q == CNT_W'(CYCLES - 1));

endmodule
`endif

// File: rtl/apb2axi_bridge.sv
// apb2axi_bridge: turns each APB access into one single-beat 32-bit AXI4 transaction.
// Optional response watchdog with DRAIN state: define APB2AXI_TIMEOUT_EN.
module apb2axi_bridge
  import apb2axi_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_USER_WIDTH = 6,
  parameter int AXI_ID_VALUE   = 0
) (
  input logic    clk_i,
  input logic    rst_i,
  input logic    test_en_i,
  APB_BUS.Slave  apb_slave,
  AXI_BUS.Master axi_master
);

  localparam int DATA_W = 32;

  if (AXI_DATA_WIDTH != DATA_W) begin : g_bad_data_width
    $error("apb2axi_bridge: AXI_DATA_WIDTH must be 32");
  end
  if (AXI_ADDR_WIDTH < APB_ADDR_WIDTH) begin : g_bad_addr_width
    $error("apb2axi_bridge: AXI_ADDR_WIDTH must be >= APB_ADDR_WIDTH");
  end

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic [DATA_W-1:0]         prdata_q, prdata_d;
  logic                      aw_valid_q, aw_valid_d;
  logic                      w_valid_q, w_valid_d;
  logic                      b_ready_q, b_ready_d;
  logic                      ar_valid_q, ar_valid_d;
  logic                      r_ready_q, r_ready_d;
  logic                      pready_q, pready_d;
  logic                      pslverr_q, pslverr_d;
  logic                      discard_q, discard_d;

`ifdef APB2AXI_TIMEOUT_EN
  logic timeout_expired;

  apb2axi_timeout #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .active_i  ((state_q == WR_RESP) || (state_q == RD_RESP)),
    .expired_o (timeout_expired)
  );
`endif

  // Next-state logic: one outstanding AXI transaction, registered handshakes and APB response.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    prdata_d   = prdata_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    ar_valid_d = ar_valid_q;
    r_ready_d  = r_ready_q;
    pready_d   = 1'b0;
    pslverr_d  = 1'b0;
    discard_d  = discard_q;

    // An APB master that walks away mid-transfer gets no response pulse.
    if ((state_q != IDLE) && !apb_slave.psel) discard_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (apb_slave.psel && apb_slave.penable) begin
          addr_d  = AXI_ADDR_WIDTH'(apb_slave.paddr);
          wdata_d = apb_slave.pwdata;
          if (apb_slave.pwrite) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            state_d    = WR_REQ;
          end else begin
            ar_valid_d = 1'b1;
            state_d    = RD_REQ;
          end
        end
      end

      WR_REQ: begin
        if (axi_master.aw_ready) aw_valid_d = 1'b0;
        if (axi_master.w_ready)  w_valid_d  = 1'b0;
        if ((!aw_valid_q || axi_master.aw_ready) && (!w_valid_q || axi_master.w_ready)) begin
          b_ready_d = 1'b1;
          state_d   = WR_RESP;
        end
      end

      WR_RESP: begin
        if (axi_master.b_valid) begin
          b_ready_d = 1'b0;
          if (discard_d) begin
            state_d = IDLE;
          end else begin
            pready_d  = 1'b1;
            pslverr_d = resp_is_err(axi_master.b_resp);
            state_d   = DONE;
          end
        end
`ifdef APB2AXI_TIMEOUT_EN
        else if (timeout_expired) begin
          pready_d  = !discard_d;
          pslverr_d = !discard_d;
          state_d   = DRAIN;
        end
`endif
      end

      RD_REQ: begin
        if (axi_master.ar_ready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = RD_RESP;
        end
      end

      RD_RESP: begin
        if (axi_master.r_valid) begin
          r_ready_d = 1'b0;
          if (discard_d) begin
            state_d = IDLE;
          end else begin
            prdata_d  = axi_master.r_data;
            pready_d  = 1'b1;
            pslverr_d = resp_is_err(axi_master.r_resp);
            state_d   = DONE;
          end
        end
`ifdef APB2AXI_TIMEOUT_EN
        else if (timeout_expired) begin
          pready_d  = !discard_d;
          pslverr_d = !discard_d;
          state_d   = DRAIN;
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

`ifdef APB2AXI_TIMEOUT_EN
      DRAIN: begin
        if ((b_ready_q && axi_master.b_valid) || (r_ready_q && axi_master.r_valid)) begin
          b_ready_d = 1'b0;
          r_ready_d = 1'b0;
          state_d   = IDLE;
        end
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any pending handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      prdata_q   <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      prdata_q   <= prdata_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      ar_valid_q <= ar_valid_d;
      r_ready_q  <= r_ready_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      discard_q  <= discard_d;
    end
  end

  assign apb_slave.prdata  = prdata_q;
  assign apb_slave.pready  = pready_q;
  assign apb_slave.pslverr = pslverr_q;

  assign axi_master.aw_id     = AXI_ID_WIDTH'(AXI_ID_VALUE);
  assign axi_master.aw_addr   = addr_q;
  assign axi_master.aw_len    = 8'd0;
  assign axi_master.aw_size   = SIZE_4B;
  assign axi_master.aw_burst  = BURST_INCR;
  assign axi_master.aw_lock   = 1'b0;
  assign axi_master.aw_cache  = 4'd0;
  assign axi_master.aw_prot   = 3'd0;
  assign axi_master.aw_qos    = 4'd0;
  assign axi_master.aw_region = 4'd0;
  assign axi_master.aw_user   = '0;
  assign axi_master.aw_valid  = aw_valid_q;

  assign axi_master.w_data    = wdata_q;
  assign axi_master.w_strb    = '1;
  assign axi_master.w_last    = 1'b1;
  assign axi_master.w_user    = '0;
  assign axi_master.w_valid   = w_valid_q;

  assign axi_master.b_ready   = b_ready_q;

  assign axi_master.ar_id     = AXI_ID_WIDTH'(AXI_ID_VALUE);
  assign axi_master.ar_addr   = addr_q;
  assign axi_master.ar_len    = 8'd0;
  assign axi_master.ar_size   = SIZE_4B;
  assign axi_master.ar_burst  = BURST_INCR;
  assign axi_master.ar_lock   = 1'b0;
  assign axi_master.ar_cache  = 4'd0;
  assign axi_master.ar_prot   = 3'd0;
  assign axi_master.ar_qos    = 4'd0;
  assign axi_master.ar_region = 4'd0;
  assign axi_master.ar_user   = '0;
  assign axi_master.ar_valid  = ar_valid_q;

  assign axi_master.r_ready   = r_ready_q;

  // test_en_i, response IDs/user bits and r_last carry no information for a single-beat bridge.
  logic unused_inputs;
  assign unused_inputs = ^{test_en_i, axi_master.b_id, axi_master.b_user,
                           axi_master.r_id, axi_master.r_last, axi_master.r_user};

endmodule

// File: tb/tb_apb2axi_bridge.sv
// tb_apb2axi_bridge: directed self-checking bench for apb2axi_bridge.
// The watchdog scenario is included when APB2AXI_TIMEOUT_EN is defined.
module tb_apb2axi_bridge;
  import apb2axi_pkg::*;

  logic clk = 1'b0;
  logic rst;

  int checkCount = 0;
  int errorCount = 0;

  int          awValidCycles;
  int          wValidCycles;
  int          bHandshakes;
  logic [31:0] lastAwAddr;
  logic [31:0] lastArAddr;
  logic [31:0] lastWData;
  logic [3:0]  lastWStrb;
  logic        lastWLast;
  logic [12:0] lastAwFixed;

  logic [31:0] rdata;
  logic        err;
  int          lat;
  logic        got;
  int          waitCount;

  always #5 clk = ~clk;

  APB_BUS #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) apbBus ();
  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32),
            .AXI_ID_WIDTH(6), .AXI_USER_WIDTH(6)) axiBus ();

  apb2axi_bridge #(
    .APB_ADDR_WIDTH (32),
    .AXI_ADDR_WIDTH (32),
    .AXI_DATA_WIDTH (32),
    .AXI_ID_WIDTH   (6),
    .AXI_USER_WIDTH (6),
    .AXI_ID_VALUE   (0)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .test_en_i  (1'b0),
    .apb_slave  (apbBus),
    .axi_master (axiBus)
  );

  // Passive AXI monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (axiBus.aw_valid) begin
      awValidCycles++;
      lastAwAddr  = axiBus.aw_addr;
      lastAwFixed = {axiBus.aw_len, axiBus.aw_size, axiBus.aw_burst};
    end
    if (axiBus.w_valid) begin
      wValidCycles++;
      lastWData = axiBus.w_data;
      lastWStrb = axiBus.w_strb;
      lastWLast = axiBus.w_last;
    end
    if (axiBus.ar_valid) lastArAddr = axiBus.ar_addr;
    if (axiBus.b_valid && axiBus.b_ready) bHandshakes++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // One full APB transfer; returns the response and the access-phase cycle in which pready rose.
  task automatic applyStimulus(input logic isWrite, input logic [31:0] addr, input logic [31:0] data,
                               input int maxCycles, output logic [31:0] rd, output logic slvErr,
                               output int latency, output logic gotReady);
    rd = '0;
    slvErr = 1'b0;
    latency = 0;
    gotReady = 1'b0;
    @(posedge clk); #1;
    apbBus.psel    = 1'b1;
    apbBus.penable = 1'b0;
    apbBus.pwrite  = isWrite;
    apbBus.paddr   = addr;
    apbBus.pwdata  = data;
    @(posedge clk); #1;
    apbBus.penable = 1'b1;
    while (!gotReady && latency < maxCycles) begin
      @(negedge clk);
      latency++;
      if (apbBus.pready) begin
        gotReady = 1'b1;
        rd       = apbBus.prdata;
        slvErr   = apbBus.pslverr;
      end
    end
    @(posedge clk); #1;
    apbBus.psel    = 1'b0;
    apbBus.penable = 1'b0;
  endtask

  task automatic clearMonitor();
    awValidCycles = 0;
    wValidCycles  = 0;
    bHandshakes   = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got hung simulation expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst = 1'b1;
    apbBus.paddr = '0; apbBus.pwdata = '0; apbBus.pwrite = 1'b0;
    apbBus.psel = 1'b0; apbBus.penable = 1'b0;
    axiBus.aw_ready = 1'b1; axiBus.w_ready = 1'b1; axiBus.ar_ready = 1'b1;
    axiBus.b_id = '0; axiBus.b_user = '0; axiBus.b_resp = RESP_OKAY; axiBus.b_valid = 1'b1;
    axiBus.r_id = '0; axiBus.r_user = '0; axiBus.r_last = 1'b1;
    axiBus.r_resp = RESP_OKAY; axiBus.r_data = 32'hDEADBEEF; axiBus.r_valid = 1'b1;
    clearMonitor();
    lastAwAddr = '0; lastArAddr = '0; lastWData = '0; lastWStrb = '0; lastWLast = 1'b0; lastAwFixed = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_ctrl", {axiBus.aw_valid, axiBus.w_valid, axiBus.b_ready, axiBus.ar_valid,
                               axiBus.r_ready, apbBus.pready, apbBus.pslverr}, 7'd0);
    checkOutput("reset_prdata", apbBus.prdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] basic write");
    applyStimulus(1'b1, 32'h0000_0040, 32'h1A2B3C4D, 40, rdata, err, lat, got);
    checkOutput("wr_got_pready", got, 1'b1);
    checkOutput("wr_latency", lat, 4);
    checkOutput("wr_pslverr", err, 1'b0);
    checkOutput("wr_aw_addr", lastAwAddr, 32'h40);
    checkOutput("wr_w_data", lastWData, 32'h1A2B3C4D);
    checkOutput("wr_w_strb", lastWStrb, 4'hF);
    checkOutput("wr_fixed_fields", {lastAwFixed, lastWLast}, {8'h00, 3'b010, 2'b01, 1'b1});
    @(negedge clk);
    checkOutput("wr_pready_one_cycle", apbBus.pready, 1'b0);

    $display("[TB] basic read");
    applyStimulus(1'b0, 32'h0000_0080, 32'h0, 40, rdata, err, lat, got);
    checkOutput("rd_got_pready", got, 1'b1);
    checkOutput("rd_latency", lat, 4);
    checkOutput("rd_prdata", rdata, 32'hDEADBEEF);
    checkOutput("rd_pslverr", err, 1'b0);
    checkOutput("rd_ar_addr", lastArAddr, 32'h80);
    @(negedge clk);
    checkOutput("rd_pready_one_cycle", apbBus.pready, 1'b0);

    $display("[TB] prdata holds across a write");
    applyStimulus(1'b1, 32'h0000_0044, 32'h0, 40, rdata, err, lat, got);
    checkOutput("hold_got_pready", got, 1'b1);
    checkOutput("hold_prdata", apbBus.prdata, 32'hDEADBEEF);

    $display("[TB] write with late w_ready");
    axiBus.w_ready = 1'b0;
    clearMonitor();
    fork
      applyStimulus(1'b1, 32'h0000_0048, 32'h5555AAAA, 40, rdata, err, lat, got);
      begin
        waitCount = 0;
        while (!axiBus.aw_valid && waitCount < 20) begin
          @(negedge clk);
          waitCount++;
        end
        repeat (3) @(posedge clk);
        #1;
        axiBus.w_ready = 1'b1;
      end
    join
    checkOutput("late_w_got_pready", got, 1'b1);
    checkOutput("late_w_aw_cycles", awValidCycles, 1);
    checkOutput("late_w_w_cycles", wValidCycles, 4);
    checkOutput("late_w_b_handshakes", bHandshakes, 1);
    checkOutput("late_w_latency", lat, 7);

    $display("[TB] error responses");
    axiBus.r_resp = RESP_SLVERR;
    axiBus.r_data = 32'h0BADF00D;
    applyStimulus(1'b0, 32'h0000_0084, 32'h0, 40, rdata, err, lat, got);
    checkOutput("slverr_rd_pslverr", err, 1'b1);
    checkOutput("slverr_rd_prdata", rdata, 32'h0BADF00D);
    axiBus.r_resp = RESP_OKAY;
    axiBus.b_resp = RESP_DECERR;
    applyStimulus(1'b1, 32'h0000_0048, 32'h1, 40, rdata, err, lat, got);
    checkOutput("decerr_wr_got_pready", got, 1'b1);
    checkOutput("decerr_wr_pslverr", err, 1'b1);
    axiBus.b_resp = RESP_OKAY;

    $display("[TB] reset while waiting for write response");
    axiBus.b_valid = 1'b0;
    @(posedge clk); #1;
    apbBus.psel = 1'b1; apbBus.penable = 1'b0; apbBus.pwrite = 1'b1;
    apbBus.paddr = 32'h0000_004C; apbBus.pwdata = 32'h12345678;
    @(posedge clk); #1;
    apbBus.penable = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_mid_b_ready_before", axiBus.b_ready, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_ctrl", {axiBus.aw_valid, axiBus.w_valid, axiBus.b_ready, axiBus.ar_valid,
                                 axiBus.r_ready, apbBus.pready, apbBus.pslverr}, 7'd0);
    checkOutput("rst_mid_prdata", apbBus.prdata, 32'h0);
    checkOutput("rst_mid_addr_data", {axiBus.aw_addr, axiBus.w_data}, 64'h0);
    apbBus.psel = 1'b0; apbBus.penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    axiBus.b_valid = 1'b1;
    axiBus.r_data  = 32'hCAFEF00D;
    applyStimulus(1'b0, 32'h0000_0088, 32'h0, 40, rdata, err, lat, got);
    checkOutput("rst_read_got_pready", got, 1'b1);
    checkOutput("rst_read_latency", lat, 4);
    checkOutput("rst_read_prdata", rdata, 32'hCAFEF00D);

`ifdef APB2AXI_TIMEOUT_EN
    $display("[TB] response watchdog");
    axiBus.b_valid = 1'b0;
    axiBus.r_data  = 32'h600DF00D;
    fork
      begin
        applyStimulus(1'b1, 32'h0000_0050, 32'hA5A5A5A5, 400, rdata, err, lat, got);
        checkOutput("wdog_got_pready", got, 1'b1);
        checkOutput("wdog_latency", lat, 259);
        checkOutput("wdog_pslverr", err, 1'b1);
        applyStimulus(1'b0, 32'h0000_0054, 32'h0, 200, rdata, err, lat, got);
        checkOutput("drain_rd_got_pready", got, 1'b1);
        checkOutput("drain_rd_stalled", lat > 20, 1'b1);
        checkOutput("drain_rd_prdata", rdata, 32'h600DF00D);
        checkOutput("drain_rd_pslverr", err, 1'b0);
      end
      begin
        repeat (300) @(posedge clk);
        #1;
        axiBus.b_valid = 1'b1;
      end
    join
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/apb2axi_bridge.md
APB2AXI_BRIDGE -- requirements
Module: apb2axi_bridge

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, AXI address width (>= APB_ADDR_WIDTH).
REQ-003 SHALL have parameter AXI_DATA_WIDTH, default 32; only 32 is supported, and any other value is an elaboration error.
REQ-004 SHALL have parameters AXI_ID_WIDTH, default 6, and AXI_USER_WIDTH, default 6, the AXI sideband widths.
REQ-005 SHALL have parameter AXI_ID_VALUE, default 0, the constant issued on aw_id/ar_id.
REQ-006 SHALL have ports, clock and reset first:
- clk_i  input  1  single clock.
- rst_i  input  1  reset, asynchronous, active-high.
- test_en_i  input  1  test enable; reserved, no functional effect.
- apb_slave  APB_BUS.Slave  -  paddr/pwdata/pwrite/psel/penable in; prdata/pready/pslverr out.
- axi_master  AXI_BUS.Master  -  full AXI4 master, all five channels.

Function
REQ-007 SHALL be an FSM with states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE.
REQ-008 IDLE SHALL detect psel&&penable and go to WR_REQ if pwrite=1, else RD_REQ.
REQ-009 On that transition it SHALL register paddr (zero-extended to AXI_ADDR_WIDTH) and pwdata.
REQ-010 WR_REQ SHALL assert aw_valid and w_valid together from the next cycle.
- Each valid SHALL drop independently on its own ready.
- The FSM SHALL move to WR_RESP once both handshakes are complete, in the same or different cycles.
REQ-011 WR_RESP SHALL hold b_ready=1; on b_valid it SHALL capture b_resp and go to DONE.
REQ-012 RD_REQ SHALL hold ar_valid until ar_ready, then go to RD_RESP.
REQ-013 RD_RESP SHALL hold r_ready=1; on r_valid it SHALL capture r_data into prdata and r_resp, then go to DONE.
REQ-014 r_last SHALL be ignored.
REQ-015 DONE SHALL assert pready=1 for exactly one cycle, then return to IDLE.
- pslverr=1 in that cycle if the captured resp is SLVERR or DECERR.
REQ-016 Fixed AXI fields SHALL be:
- len=0, size=3'b010, burst=INCR, last=1, strb=4'hF.
- lock, cache, prot, region, qos, user = 0.
REQ-017 pready SHALL be registered.
- Minimum write latency, access-phase cycle to pready high: 4 cycles, with aw/w ready and b_valid all immediate.
- Minimum read latency: 4 cycles.
REQ-018 If psel drops before DONE, the AXI transaction SHALL still complete, the response SHALL be discarded and no pready pulse SHALL be issued.
REQ-019 prdata SHALL hold its last read value until the next read completes.
REQ-020 Only one outstanding AXI transaction is allowed; no new APB access is accepted outside IDLE.

Reset
REQ-021 rst_i high SHALL force asynchronously:
- state to IDLE.
- all valid/ready outputs, pready and pslverr to 0.
- prdata and the address/data registers to 0.
REQ-022 Reset mid-transaction SHALL abandon any pending AXI handshake without completing it.

Configuration
REQ-023 With APB2AXI_TIMEOUT_EN defined, a watchdog SHALL count cycles spent in WR_RESP/RD_RESP.
- On reaching TIMEOUT_CYCLES (256) it SHALL pulse pready with pslverr=1 and enter DRAIN.
- DRAIN SHALL keep b_ready/r_ready high until the late response arrives, then return to IDLE.
- New APB accesses SHALL stall during DRAIN.
REQ-024 Without APB2AXI_TIMEOUT_EN, no counter or DRAIN state SHALL exist, and the bridge SHALL wait for a response indefinitely.

Structure
REQ-025 Package apb2axi_pkg SHALL hold:
- the state enum.
- the constants RESP_OKAY/EXOKAY/SLVERR/DECERR, BURST_INCR, SIZE_4B and TIMEOUT_CYCLES.
REQ-026 The watchdog SHALL be sub-module apb2axi_timeout, instantiated only under APB2AXI_TIMEOUT_EN.

Verification
REQ-027 Write 0x1A2B3C4D to 0x0000_0040 with aw/w ready=1 and b_resp=OKAY -> aw_addr=0x40, w_data=0x1A2B3C4D, w_strb=F, pready high on the 4th cycle, pslverr=0.
REQ-028 Read 0x0000_0080 with r_data=0xDEADBEEF and r_resp=OKAY -> prdata=0xDEADBEEF, pready high for exactly one cycle.
REQ-029 Write where w_ready arrives 3 cycles after aw_ready -> aw_valid drops after 1 cycle, w_valid holds 4 cycles, a single b handshake follows.
REQ-030 Read with r_resp=SLVERR, then write with b_resp=DECERR -> pslverr=1 on both pready cycles.
REQ-031 rst_i asserted in WR_RESP, then a fresh read -> outputs zero immediately, and the read completes normally.
REQ-032 With APB2AXI_TIMEOUT_EN and b_valid withheld for 300 cycles -> pready/pslverr=1 at cycle 256; a following APB access stalls until b_valid arrives, then completes.
